// File: rtl/vc_fifo_if.sv
// Write/read port bundle for vc_fifo: one push port, one pop port and the
// per-channel status/head-data outputs.
interface vc_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_VC     = 2
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                         wr_en;
    logic [VC_W-1:0]              wr_vc;
    logic [DATA_WIDTH-1:0]        din;
    logic                         rd_en;
    logic [VC_W-1:0]              rd_vc;
    logic [NUM_VC*DATA_WIDTH-1:0] dout;
    logic [NUM_VC-1:0]            empty;
    logic [NUM_VC-1:0]            full;
    logic [NUM_VC-1:0]            almost_full;
    logic [NUM_VC*CNT_W-1:0]      count;
    logic                         wr_drop;

    modport master (
        output wr_en, wr_vc, din, rd_en, rd_vc,
        input  dout, empty, full, almost_full, count, wr_drop
    );

    modport slave (
        input  wr_en, wr_vc, din, rd_en, rd_vc,
        output dout, empty, full, almost_full, count, wr_drop
    );
endinterface

// File: rtl/vc_fifo.sv
// Multi-VC input buffer: NUM_VC FIFOs sharing one storage array, FWFT heads.
// Define VC_FIFO_ALMOST_FULL_EN to drive almost_full from AF_THRESHOLD.

module vc_fifo_ch #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] head,
    output logic [ADDR_W-1:0] tail,
    output logic [CNT_W-1:0]  count
);
    // push/pop arrive already qualified against full/empty, so count cannot wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) head <= head + ADDR_W'(1);
            if (pop)  tail <= tail + ADDR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

module vc_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int NUM_VC       = 2,
    parameter int AF_THRESHOLD = FIFO_DEPTH - 2
) (
    input  logic       clk,
    input  logic       rst,
    vc_fifo_if.slave   bus
);
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int MEM_W  = NUM_VC * FIFO_DEPTH;
    localparam int MEM_AW = (MEM_W > 1) ? $clog2(MEM_W) : 1;

    logic [NUM_VC-1:0]                 push_ok, pop_ok, empty_v, full_v, af_v;
    logic [NUM_VC-1:0][ADDR_W-1:0]     head, tail;
    logic [NUM_VC-1:0][CNT_W-1:0]      cnt;
    logic [NUM_VC-1:0][DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0]             mem [MEM_W];
    logic [MEM_AW-1:0]                 wr_addr;
    logic                              drop_q;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_ch
        assign empty_v[v] = (cnt[v] == '0);
        assign full_v[v]  = (cnt[v] == CNT_W'(FIFO_DEPTH));
        // An out-of-range VC matches no channel, so it is never accepted
        assign push_ok[v] = bus.wr_en && (bus.wr_vc == VC_W'(v)) && !full_v[v];
        assign pop_ok[v]  = bus.rd_en && (bus.rd_vc == VC_W'(v)) && !empty_v[v];

        vc_fifo_ch #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .push  (push_ok[v]),
            .pop   (pop_ok[v]),
            .head  (head[v]),
            .tail  (tail[v]),
            .count (cnt[v])
        );

        assign head_data[v] = empty_v[v] ? '0
                            : mem[MEM_AW'(v * FIFO_DEPTH) + MEM_AW'(tail[v])];

`ifdef VC_FIFO_ALMOST_FULL_EN
        assign af_v[v] = (int'(cnt[v]) >= AF_THRESHOLD);
`else
        assign af_v[v] = 1'b0;
`endif
    end

`ifndef VC_FIFO_ALMOST_FULL_EN
    localparam int af_threshold_unused = AF_THRESHOLD;
`endif

    always_comb begin
        wr_addr = '0;
        for (int v = 0; v < NUM_VC; v++)
            if (push_ok[v]) wr_addr = MEM_AW'(v * FIFO_DEPTH) + MEM_AW'(head[v]);
    end

    always_ff @(posedge clk) begin
        if (!rst && |push_ok) mem[wr_addr] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= 1'b0;
        else     drop_q <= bus.wr_en && !(|push_ok);
    end

    assign bus.dout        = head_data;
    assign bus.count       = cnt;
    assign bus.empty       = empty_v;
    assign bus.full        = full_v;
    assign bus.almost_full = af_v;
    assign bus.wr_drop     = drop_q;
endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo (2 VCs x 4 entries); almost_full expectations
// follow VC_FIFO_ALMOST_FULL_EN.
module tb_vc_fifo;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int NVC = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_run = 0;
    int   n_fail = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    vc_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_VC(NVC)) bus ();

    vc_fifo #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .NUM_VC       (NVC),
        .AF_THRESHOLD (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dq(input int v);
        return bus.dout[v*DW +: DW];
    endfunction

    function automatic logic [2:0] cq(input int v);
        return bus.count[v*CW +: CW];
    endfunction

    function automatic logic [1:0] exp_af(input int c0, input int c1);
`ifdef VC_FIFO_ALMOST_FULL_EN
        return {1'(c1 >= 2), 1'(c0 >= 2)};
`else
        return 2'b00;
`endif
    endfunction

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic push(input int v, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.wr_vc = 1'(v);
        bus.din   = d;
    endtask

    task automatic pop(input int v);
        bus.rd_en = 1'b1;
        bus.rd_vc = 1'(v);
    endtask

    initial begin
        logic [31:0] a_exp [4];
        a_exp[0] = 32'hA1; a_exp[1] = 32'hA2; a_exp[2] = 32'hA3; a_exp[3] = 32'h0;

        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_vc = '0; bus.din = '0;
        bus.rd_en = 1'b0; bus.rd_vc = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_empty", 64'(bus.empty), 64'h3);
        chk("rst_full", 64'(bus.full), 64'h0);
        chk("rst_count", 64'(bus.count), 64'h0);
        chk("rst_dout", 64'(bus.dout), 64'h0);
        chk("rst_drop", 64'(bus.wr_drop), 64'h0);
        chk("rst_af", 64'(bus.almost_full), 64'h0);

        // fill VC0
        for (int i = 0; i < 4; i++) begin
            push(0, 32'hA0 + 32'(i));
            tick();
            chk("fill_cnt0", 64'(cq(0)), 64'(i + 1));
            chk("fill_dout0", 64'(dq(0)), 64'hA0);
            chk("fill_empty1", 64'(bus.empty[1]), 64'h1);
            chk("fill_af", 64'(bus.almost_full), 64'(exp_af(i + 1, 0)));
        end
        idle();
        chk("fill_full", 64'(bus.full), 64'h1);

        // push into full VC0
        push(0, 32'hA4);
        tick();
        idle();
        chk("ovf_drop", 64'(bus.wr_drop), 64'h1);
        chk("ovf_cnt0", 64'(cq(0)), 64'h4);
        tick();
        chk("ovf_drop_clr", 64'(bus.wr_drop), 64'h0);

        // drain VC0
        for (int i = 0; i < 4; i++) begin
            pop(0);
            tick();
            chk("drain_dout0", 64'(dq(0)), 64'(a_exp[i]));
            chk("drain_cnt0", 64'(cq(0)), 64'(3 - i));
            chk("drain_af", 64'(bus.almost_full), 64'(exp_af(3 - i, 0)));
        end
        idle();
        chk("drain_empty", 64'(bus.empty), 64'h3);

        // rejected pop on empty channel: no effect, no flag
        pop(0);
        tick();
        idle();
        chk("upop_cnt", 64'(bus.count), 64'h0);
        chk("upop_drop", 64'(bus.wr_drop), 64'h0);

        // preload VC0, then alternate push/pop across channels with a queue model
        for (int i = 0; i < 3; i++) begin
            push(0, 32'hD0 + 32'(i));
            q0.push_back(32'hD0 + 32'(i));
            tick();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            int wv;
            int rv;
            logic [31:0] d;
            wv = i % 2;
            rv = 1 - wv;
            d = 32'hB0 + 32'(i);
            push(wv, d);
            pop(rv);
            if (rv == 0 && q0.size() > 0) void'(q0.pop_front());
            if (rv == 1 && q1.size() > 0) void'(q1.pop_front());
            if (wv == 0 && q0.size() < DEPTH) q0.push_back(d);
            if (wv == 1 && q1.size() < DEPTH) q1.push_back(d);
            tick();
            chk("mix_cnt0", 64'(cq(0)), 64'(q0.size()));
            chk("mix_cnt1", 64'(cq(1)), 64'(q1.size()));
            chk("mix_dout0", 64'(dq(0)), 64'(q0.size() > 0 ? q0[0] : 32'h0));
            chk("mix_dout1", 64'(dq(1)), 64'(q1.size() > 0 ? q1[0] : 32'h0));
        end
        idle();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_count", 64'(bus.count), 64'h0);

        // same-channel push+pop on empty VC1
        push(1, 32'hE1);
        pop(1);
        tick();
        idle();
        chk("same_e_cnt1", 64'(cq(1)), 64'h1);
        chk("same_e_dout1", 64'(dq(1)), 64'hE1);
        chk("same_e_drop", 64'(bus.wr_drop), 64'h0);
        for (int i = 0; i < 3; i++) begin
            push(1, 32'hE2 + 32'(i));
            tick();
        end
        idle();
        chk("same_f_full", 64'(bus.full), 64'h2);

        // same-channel push+pop on full VC1
        push(1, 32'hE5);
        pop(1);
        tick();
        idle();
        chk("same_f_cnt1", 64'(cq(1)), 64'h3);
        chk("same_f_drop", 64'(bus.wr_drop), 64'h1);
        chk("same_f_dout1", 64'(dq(1)), 64'hE2);
        pop(1); tick();
        chk("same_f_pop1", 64'(dq(1)), 64'hE3);
        pop(1); tick();
        chk("same_f_pop2", 64'(dq(1)), 64'hE4);
        pop(1); tick();
        idle();
        chk("same_f_pop3", 64'(dq(1)), 64'h0);
        chk("same_f_cnt_end", 64'(cq(1)), 64'h0);

        // reset while VC0 holds 3 entries and a push is in flight
        for (int i = 0; i < 3; i++) begin
            push(0, 32'hF0 + 32'(i));
            tick();
        end
        chk("pre_rst_cnt0", 64'(cq(0)), 64'h3);
        push(0, 32'hF3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("rst3_count", 64'(bus.count), 64'h0);
        chk("rst3_empty", 64'(bus.empty), 64'h3);
        chk("rst3_dout", 64'(bus.dout), 64'h0);
        tick();
        chk("rst3_lost", 64'(bus.count), 64'h0);
        chk("rst3_drop", 64'(bus.wr_drop), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/vc_fifo.md
# vc_fifo

Multi-channel input buffer for mesh router ports: NUM_VC independent FIFOs (one per virtual channel) behind one write port and one read port, all sharing one storage array. Each channel has its own head/tail pointers and occupancy counter. Because fullness comes from the counter, all FIFO_DEPTH entries are usable. Head-of-queue data for every channel is presented first-word-fall-through, so the router's route computation and arbitration can inspect all channels without popping. Sits between the link input and the switch allocator.

## Interface
- DATA_WIDTH, 32, flit width in bits
- FIFO_DEPTH, 8, entries per channel; power of two, >= 2
- NUM_VC, 2, number of channels; >= 1
- AF_THRESHOLD, FIFO_DEPTH-2, almost_full asserts when count >= this value (used only with VC_FIFO_ALMOST_FULL_EN)
- VC_W (localparam), max(1, $clog2(NUM_VC))
- ADDR_W (localparam), $clog2(FIFO_DEPTH)
- CNT_W (localparam), $clog2(FIFO_DEPTH+1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  push request
- wr_vc  in  VC_W  target channel of the push
- din  in  DATA_WIDTH  push data
- rd_en  in  1  pop request
- rd_vc  in  VC_W  channel to pop
- dout  out  NUM_VC*DATA_WIDTH  head entry of each channel; channel v at bits [v*DATA_WIDTH +: DATA_WIDTH]
- empty  out  NUM_VC  per-channel empty flag
- full  out  NUM_VC  per-channel full flag
- almost_full  out  NUM_VC  per-channel almost-full flag
- count  out  NUM_VC*CNT_W  per-channel occupancy; channel v at bits [v*CNT_W +: CNT_W]
- wr_drop  out  1  registered pulse: the previous cycle's push was rejected (full channel or wr_vc >= NUM_VC)

## Operation
- Storage: NUM_VC*FIFO_DEPTH words. Channel v owns addresses v*FIFO_DEPTH to v*FIFO_DEPTH+FIFO_DEPTH-1.
- Synchronous write, asynchronous read; the array is not reset.
- Push is accepted when wr_en, wr_vc < NUM_VC and !full[wr_vc]. On accept: write din at head[wr_vc], head increments (mod FIFO_DEPTH), count increments.
- Pop is accepted when rd_en, rd_vc < NUM_VC and !empty[rd_vc]. On accept: tail increments (mod FIFO_DEPTH), count decrements.
- A rejected pop has no effect and no flag.
- A rejected push sets wr_drop to 1 for exactly the next cycle. Storage and pointers are unchanged.
- empty[v] = (count[v] == 0). full[v] = (count[v] == FIFO_DEPTH).
- dout slice v = storage[v, tail[v]] when !empty[v], else 0.
- Simultaneous push and pop, different channels: both proceed independently.
- Simultaneous push and pop, same channel, non-empty and non-full: both proceed; count is unchanged.
- Same channel, empty: the push is accepted and the pop is ignored; count becomes 1.
- Same channel, full: the push is rejected (wr_drop pulses) and the pop is accepted; count becomes FIFO_DEPTH-1. A full channel never accepts a push in the same cycle as a pop.
- Pointers wrap naturally at FIFO_DEPTH; count never wraps.
- Reset: all head, tail and count values go to 0, and wr_drop goes to 0. After reset, empty is all-ones, full is all-zeros, almost_full is all-zeros and dout is all-zeros. Reset overrides any push or pop in the same cycle; in-flight contents are discarded.

## Timing
- Push at edge N: data appears on dout (if it is the channel head), and empty/count/full update, in the cycle after edge N. Write-to-read latency is 1 cycle; there is no same-cycle bypass.
- Pop at edge N: the next entry appears on dout in the cycle after edge N.
- empty, full, almost_full, count and dout are combinational from registered state only. They have no combinational path from wr_en, rd_en, din, wr_vc or rd_vc.
- wr_drop is a register, valid one cycle after the rejected push.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- VC_FIFO_ALMOST_FULL_EN defined: almost_full[v] = (count[v] >= AF_THRESHOLD). Used for credit/backpressure lookahead.
- Not defined: almost_full is tied to 0 and AF_THRESHOLD is ignored. All other behaviour is identical.

## Test plan
(NUM_VC=2, FIFO_DEPTH=4, DATA_WIDTH=32)
- Reset, then push 0xA0..0xA3 into VC0 -> count0 = 1,2,3,4 over successive cycles; full[0]=1 after the 4th push; VC1 stays empty; dout VC0 = 0xA0 throughout.
- VC0 full, push 0xA4 -> wr_drop=1 next cycle; count0 stays 4. Then pop 4 times -> dout VC0 = 0xA1, 0xA2, 0xA3, then 0; empty[0]=1.
- Interleave: push 0xB0 to VC1 and pop VC0 in the same cycle, repeated for 16 cycles with continuous refills -> no cross-channel corruption; pointers wrap and data order is preserved.
- Same-channel push+pop on an empty VC -> count=1 and dout = pushed value. On a full VC -> count=3, wr_drop=1, and the pushed value is absent.
- With VC_FIFO_ALMOST_FULL_EN and AF_THRESHOLD=2 -> almost_full[0] rises when count0 reaches 2 and falls when it drops to 1. Without the macro -> almost_full is 0 at all times.
- Assert rst with VC0 holding 3 entries while pushing -> next cycle all counts are 0, empty=2'b11 and dout=0; the concurrent push is lost.
